// File: rtl/outcount_led_ctrl_n.sv
// Out-count controller: counts outs to MAX_OUT, holds the full LED bar for HOLD_CYCLES,
// then pulses change_pulse for one cycle and flips the top/bottom side indicator.
module outcount_led_ctrl_n #(
  parameter int unsigned MAX_OUT        = 3,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter bit          LED_ACTIVE_LOW = 1'b1,
  localparam int unsigned CW            = $clog2(MAX_OUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               out_pulse,
  input  logic               undo_pulse,
  input  logic               clear_pulse,
  output logic [MAX_OUT-1:0] out_led,
  output logic [CW-1:0]      count,
  output logic               change_pulse,
  output logic               side,
  output logic               busy
);

  localparam logic LIT   = ~LED_ACTIVE_LOW;
  localparam logic UNLIT = LED_ACTIVE_LOW;
  localparam int unsigned HW = 8;

  typedef enum logic [1:0] {
    S_COUNT  = 2'd0,
    S_HOLD   = 2'd1,
    S_CHANGE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               side_q, side_d;
  logic               change_q, change_d;
  logic               busy_q, busy_d;
  logic [MAX_OUT-1:0] led_q, led_d;

  logic out_only, undo_only, at_last_out;

  assign out_only    = out_pulse & ~undo_pulse;
  assign undo_only   = undo_pulse & ~out_pulse;
  assign at_last_out = (count_q == CW'(MAX_OUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_COUNT;
      count_q  <= '0;
      hold_q   <= '0;
      side_q   <= 1'b0;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
      led_q    <= {MAX_OUT{UNLIT}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      side_q   <= side_d;
      change_q <= change_d;
      busy_q   <= busy_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COUNT: begin
        if (!clear_pulse && out_only && at_last_out)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        if (clear_pulse || undo_only)
          state_d = S_COUNT;
        else if (hold_q == HW'(1))
          state_d = S_CHANGE;
      end
      S_CHANGE: state_d = S_COUNT;
      default:  state_d = S_COUNT;
    endcase
  end

  always_comb begin
    count_d = count_q;
    hold_d  = hold_q;
    side_d  = side_q;
    case (state_q)
      S_COUNT: begin
        if (clear_pulse) begin
          count_d = '0;
        end else if (out_only) begin
          count_d = count_q + CW'(1);
          if (at_last_out)
            hold_d = HW'(HOLD_CYCLES);
        end else if (undo_only && count_q != '0) begin
          count_d = count_q - CW'(1);
        end
      end
      S_HOLD: begin
        hold_d = hold_q - HW'(1);
        if (clear_pulse) begin
          count_d = '0;
          hold_d  = '0;
        end else if (undo_only) begin
          count_d = CW'(MAX_OUT - 1);
          hold_d  = '0;
        end else if (hold_q == HW'(1)) begin
          count_d = '0;
          side_d  = ~side_q;
        end
      end
      default: begin
        // CHANGE and any illegal encoding land on an empty count; side is kept.
        count_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    change_d = (state_d == S_CHANGE);
    busy_d   = (state_d != S_COUNT);
    led_d    = {MAX_OUT{UNLIT}};
    for (int i = 0; i < int'(MAX_OUT); i++)
      led_d[i] = (CW'(i) < count_d) ? LIT : UNLIT;
  end

  assign out_led      = led_q;
  assign count        = count_q;
  assign change_pulse = change_q;
  assign side         = side_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_outcount_led_ctrl_n.sv
// Bench for outcount_led_ctrl_n: two instances (3 outs active-low, 5 outs active-high)
// share stimulus; a behavioural model feeds per-instance expectation queues.
module tb_outcount_led_ctrl_n;

  logic clk = 1'b0;
  logic reset;
  logic out_p, undo_p, clear_p;

  logic [2:0] a_led;
  logic [1:0] a_cnt;
  logic       a_chg, a_side, a_busy;
  logic [4:0] b_led;
  logic [2:0] b_cnt;
  logic       b_chg, b_side, b_busy;

  outcount_led_ctrl_n #(.MAX_OUT(3), .HOLD_CYCLES(4), .LED_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .out_pulse(out_p), .undo_pulse(undo_p), .clear_pulse(clear_p),
    .out_led(a_led), .count(a_cnt), .change_pulse(a_chg), .side(a_side), .busy(a_busy));

  outcount_led_ctrl_n #(.MAX_OUT(5), .HOLD_CYCLES(4), .LED_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(reset), .out_pulse(out_p), .undo_pulse(undo_p), .clear_pulse(clear_p),
    .out_led(b_led), .count(b_cnt), .change_pulse(b_chg), .side(b_side), .busy(b_busy));

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int led;
    int side;
    int chg;
    int busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = counting, 1 = holding full bar, 2 = side-change cycle.
  int m_cnt[2], m_hold[2], m_side[2], m_ph[2];
  int mmax[2] = '{3, 5};
  int mlow[2] = '{1, 0};
  localparam int HOLD = 4;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_hold[k] = 0; m_side[k] = 0; m_ph[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit o, bit u, bit c);
    if (m_ph[k] == 0) begin
      if (c) m_cnt[k] = 0;
      else if (o && u) ;
      else if (o) begin
        m_cnt[k]++;
        if (m_cnt[k] == mmax[k]) begin m_ph[k] = 1; m_hold[k] = HOLD; end
      end else if (u && m_cnt[k] > 0) m_cnt[k]--;
    end else if (m_ph[k] == 1) begin
      if (c) begin m_cnt[k] = 0; m_ph[k] = 0; end
      else if (u && !o) begin m_cnt[k] = mmax[k] - 1; m_ph[k] = 0; end
      else begin
        m_hold[k]--;
        if (m_hold[k] == 0) begin m_ph[k] = 2; m_cnt[k] = 0; m_side[k] ^= 1; end
      end
    end else begin
      m_ph[k] = 0;
    end
  endtask

  function automatic exp_t expect_of(int k);
    exp_t e;
    e.cnt  = m_cnt[k];
    e.side = m_side[k];
    e.chg  = (m_ph[k] == 2) ? 1 : 0;
    e.busy = (m_ph[k] != 0) ? 1 : 0;
    e.led  = 0;
    for (int i = 0; i < mmax[k]; i++)
      if ((m_cnt[k] > i) != (mlow[k] == 1)) e.led |= (1 << i);
    return e;
  endfunction

  task automatic cycle(bit o, bit u, bit c);
    @(negedge clk);
    out_p = o; undo_p = u; clear_p = c;
    model_step(0, o, u, c);
    model_step(1, o, u, c);
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    @(posedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_a_count"}, a_cnt, 0);
    chk({tag, "_a_led"}, a_led, 7);
    chk({tag, "_a_side"}, a_side, 0);
    chk({tag, "_a_chg"}, a_chg, 0);
    chk({tag, "_a_busy"}, a_busy, 0);
    chk({tag, "_b_count"}, b_cnt, 0);
    chk({tag, "_b_led"}, b_led, 0);
    chk({tag, "_b_side"}, b_side, 0);
    chk({tag, "_b_busy"}, b_busy, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_count", a_cnt, ea.cnt);
      chk("a_led", a_led, ea.led);
      chk("a_side", a_side, ea.side);
      chk("a_change", a_chg, ea.chg);
      chk("a_busy", a_busy, ea.busy);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_count", b_cnt, eb.cnt);
      chk("b_led", b_led, eb.led);
      chk("b_side", b_side, eb.side);
      chk("b_change", b_chg, eb.chg);
      chk("b_busy", b_busy, eb.busy);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; out_p = 0; undo_p = 0; clear_p = 0;
    model_reset();
    #7;
    reset_checks("reset");
    @(negedge clk);
    reset = 1'b0;

    // Three outs, hold, change; repeated so side returns to 0.
    for (int rep = 0; rep < 2; rep++) begin
      cycle(1, 0, 0); idle(1); cycle(1, 0, 0); idle(1); cycle(1, 0, 0);
      #2;
      chk("tp2_a_led_full", a_led, 0);
      chk("tp2_a_busy", a_busy, 1);
      idle(4);
      #2;
      chk("tp2_a_change", a_chg, 1);
      chk("tp2_a_side", a_side, (rep == 0) ? 1 : 0);
      idle(1);
    end

    // Undo in the second hold cycle, then re-enter hold.
    cycle(0, 0, 1);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    idle(1);
    cycle(0, 1, 0);
    #2;
    chk("tp3_a_count", a_cnt, 2);
    chk("tp3_a_led", a_led, 3'b100);
    cycle(1, 0, 0);
    idle(6);

    // Simultaneous pulses and floor behaviour.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    cycle(1, 0, 0); cycle(1, 0, 0);
    cycle(1, 0, 1);
    #2;
    chk("tp4_a_clear_wins", a_cnt, 0);

    // Clear during hold; inputs ignored during change.
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    idle(1);
    cycle(0, 0, 1);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    idle(4);
    cycle(1, 1, 1);
    idle(2);

    // Five outs on the wide instance.
    cycle(0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    #2;
    chk("tp6_b_led_full", b_led, 5'b11111);
    idle(6);

    for (int n = 0; n < 1500; n++)
      cycle($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);

    // Asynchronous reset between edges while holding.
    cycle(0, 0, 1);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    idle(2);
    #3;
    reset = 1'b1;
    #1;
    reset_checks("async_rst");
    model_reset();
    @(negedge clk);
    out_p = 0; undo_p = 0; clear_p = 0;
    reset = 1'b0;

    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);

    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
